// File: rtl/lfsr_share_arbiter_pkg.sv
// lfsr_share_arbiter_pkg: FSM state type, LFSR lock-up constants and parameter defaults
package lfsr_share_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, WARM, RUN} state_t;
  localparam logic [15:0] LFSR_LOCKUP = 16'hFFFF;
  localparam logic [15:0] LFSR_LOCKUP_FIX = 16'hFFFE;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WARMUP = 16;
  function automatic logic [15:0] sanitize_seed(input logic [15:0] s);
    return s == LFSR_LOCKUP ? LFSR_LOCKUP_FIX : s;
  endfunction
endpackage

// File: rtl/lfsr_share_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin one-hot pick, searching upward from ptr with wrap
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] idx
);
  localparam int PW = $clog2(NUM_REQ);
  int j;
  logic found;
  // First active request at or after ptr wins; no request leaves gnt at zero
  always_comb begin
    gnt = '0;
    idx = '0;
    found = 1'b0;
    j = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[j]) begin
        gnt[j] = 1'b1;
        idx = PW'(j);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/lfsr_share_arbiter.sv
// lfsr_share_arbiter: seeds and warms a shared 16-bit LFSR, then hands its words out round-robin; grant statistics under LFSR_SHARE_ARBITER_STATS_EN
module lfsr_share_arbiter
  import lfsr_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WARMUP  = DEF_WARMUP
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               seed_load,
  input  logic [15:0]        seed,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [15:0]        rand_out,
  output logic               rand_valid,
  output logic               ready,
  output logic               gen_load,
  output logic [15:0]        gen_seed,
  input  logic [15:0]        gen_rand
`ifdef LFSR_SHARE_ARBITER_STATS_EN
  ,
  input  logic [2:0]         stat_sel,
  input  logic               stat_clr,
  output logic [15:0]        stat_cnt
`endif
);
  localparam int PW = $clog2(NUM_REQ);
  state_t state_q, state_d;
  logic [7:0] warm_q, warm_d;
  logic [PW-1:0] ptr, pick_idx, ptr_nxt;
  logic [NUM_REQ-1:0] pick;
  logic issue;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req(req),
    .ptr(ptr),
    .gnt(pick),
    .idx(pick_idx)
  );

  assign issue = state_q == RUN && !seed_load && |req;
  assign ready = state_q == RUN;
  assign gen_load = state_q == LOAD;
  assign ptr_nxt = pick_idx == PW'(NUM_REQ - 1) ? '0 : pick_idx + 1'b1;

  // State register and warm-up counter
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state_q <= IDLE;
      warm_q <= '0;
    end else begin
      state_q <= state_d;
      warm_q <= warm_d;
    end

  // Next state: a seed load restarts from LOAD anywhere; WARM counts down to zero before RUN
  always_comb begin
    state_d = state_q;
    warm_d = warm_q;
    if (seed_load) state_d = LOAD;
    else case (state_q)
      LOAD: begin
        state_d = WARM;
        warm_d = 8'(WARMUP - 1);
      end
      WARM: begin
        state_d = warm_q == '0 ? RUN : WARM;
        warm_d = warm_q == '0 ? warm_q : warm_q - 8'd1;
      end
      default: ;
    endcase
  end

  // Grant and word registers; the seed is captured sanitised and the pointer rewinds on a load
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      gnt <= '0;
      rand_valid <= 1'b0;
      rand_out <= '0;
      gen_seed <= '0;
      ptr <= '0;
    end else begin
      gnt <= issue ? pick : '0;
      rand_valid <= issue;
      rand_out <= issue ? gen_rand : rand_out;
      gen_seed <= seed_load ? sanitize_seed(seed) : gen_seed;
      ptr <= seed_load ? '0 : issue ? ptr_nxt : ptr;
    end

`ifdef LFSR_SHARE_ARBITER_STATS_EN
  logic [15:0] cnt [NUM_REQ];

  // Saturating per-requester grant counters; clear beats a same-cycle grant, seed loads leave them alone
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) for (int k = 0; k < NUM_REQ; k++) cnt[k] <= '0;
    else for (int k = 0; k < NUM_REQ; k++)
      cnt[k] <= stat_clr ? '0 : issue && pick[k] && cnt[k] != 16'hFFFF ? cnt[k] + 16'd1 : cnt[k];

  // Combinational read of the selected counter; out-of-range selects read zero
  always_comb begin
    stat_cnt = '0;
    for (int k = 0; k < NUM_REQ; k++) if (stat_sel == 3'(k)) stat_cnt = cnt[k];
  end
`endif
endmodule

// File: tb/tb_lfsr_share_arbiter.sv
// tb_lfsr_share_arbiter: scoreboard bench for lfsr_share_arbiter driving an XNOR LFSR reference generator
module tb_lfsr_share_arbiter;
  localparam int W = 16;
  logic clock = 1'b0, resetn = 1'b1, seed_load = 1'b0;
  logic [15:0] seed = '0;
  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic [15:0] rand_out, gen_seed, gen_rand;
  logic rand_valid, ready, gen_load;
`ifdef LFSR_SHARE_ARBITER_STATS_EN
  logic [2:0] stat_sel = '0;
  logic stat_clr = 1'b0;
  logic [15:0] stat_cnt;
`endif
  int applied = 0, miscompares = 0;
  logic [19:0] exp_q[$];
  logic [15:0] mstate = '0, last_rand = '0;
  logic lockup_seen = 1'b0;

  always #5 clock = ~clock;

  lfsr_share_arbiter dut (
    .clock(clock),
    .resetn(resetn),
    .seed_load(seed_load),
    .seed(seed),
    .req(req),
    .gnt(gnt),
    .rand_out(rand_out),
    .rand_valid(rand_valid),
    .ready(ready),
    .gen_load(gen_load),
    .gen_seed(gen_seed),
    .gen_rand(gen_rand)
`ifdef LFSR_SHARE_ARBITER_STATS_EN
    ,
    .stat_sel(stat_sel),
    .stat_clr(stat_clr),
    .stat_cnt(stat_cnt)
`endif
  );

  function automatic logic [15:0] step(input logic [15:0] s);
    return {s[14:0], ~(s[15] ^ s[14] ^ s[12] ^ s[3])};
  endfunction

  function automatic logic [15:0] step_n(input logic [15:0] s, input int n);
    logic [15:0] r;
    r = s;
    for (int i = 0; i < n; i++) r = step(r);
    return r;
  endfunction

  // Reference XNOR LFSR generator sitting outside the arbiter
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) gen_rand <= 16'h0001;
    else gen_rand <= gen_load ? gen_seed : step(gen_rand);

  always_ff @(posedge clock)
    if (gen_rand == 16'hFFFF) lockup_seen <= 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every presented grant must match the oldest expected {gnt, word}
  always @(negedge clock)
    if (resetn && (rand_valid || gnt != 4'b0000)) begin
      if (exp_q.size() == 0) check("unexpected grant", {11'h0, rand_valid, gnt, rand_out}, 32'h0);
      else check("grant", {11'h0, rand_valid, gnt, rand_out}, {11'h0, 1'b1, exp_q.pop_front()});
    end

  task automatic pulse(input logic [15:0] s, input logic [15:0] exp_seed);
    seed_load = 1'b1;
    seed = s;
    @(negedge clock);
    seed_load = 1'b0;
    check("gen_load in LOAD", {31'h0, gen_load}, 32'h1);
    check("gen_seed", {16'h0, gen_seed}, {16'h0, exp_seed});
  endtask

  task automatic warm(input logic [15:0] exp_seed);
    for (int i = 1; i <= W; i++) begin
      @(negedge clock);
      if (i == 1) check("gen_load one cycle", {31'h0, gen_load}, 32'h0);
    end
    check("ready during warm", {31'h0, ready}, 32'h0);
    @(negedge clock);
    check("ready after warm", {31'h0, ready}, 32'h1);
    mstate = step_n(exp_seed, W);
  endtask

  task automatic cyc(input logic [3:0] r, input logic [3:0] e);
    req = r;
    if (e != 4'b0000) begin
      exp_q.push_back({e, mstate});
      last_rand = mstate;
    end
    @(negedge clock);
    mstate = step(mstate);
  endtask

  initial begin
    #1 resetn = 1'b0;
    #1;
    check("reset gnt", {28'h0, gnt}, 32'h0);
    check("reset rand_valid", {31'h0, rand_valid}, 32'h0);
    check("reset rand_out", {16'h0, rand_out}, 32'h0);
    check("reset ready", {31'h0, ready}, 32'h0);
    check("reset gen_load", {31'h0, gen_load}, 32'h0);
    check("reset gen_seed", {16'h0, gen_seed}, 32'h0);
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    req = 4'b1111;
    repeat (4) @(negedge clock);
    check("idle not ready", {31'h0, ready}, 32'h0);
    req = 4'b0000;
    pulse(16'hACE1, 16'hACE1);
    warm(16'hACE1);
    cyc(4'b1111, 4'b0001);
    cyc(4'b1111, 4'b0010);
    cyc(4'b1111, 4'b0100);
    cyc(4'b1111, 4'b1000);
    cyc(4'b1111, 4'b0001);
    cyc(4'b0000, 4'b0000);
    check("idle rand_valid", {31'h0, rand_valid}, 32'h0);
    check("idle rand_out hold", {16'h0, rand_out}, {16'h0, last_rand});
    cyc(4'b0000, 4'b0000);
    cyc(4'b0100, 4'b0100);
    cyc(4'b1011, 4'b1000);
    cyc(4'b0000, 4'b0000);
    pulse(16'hFFFF, 16'hFFFE);
    warm(16'hFFFE);
    cyc(4'b0010, 4'b0010);
    cyc(4'b0000, 4'b0000);
    req = 4'b1111;
    pulse(16'h1234, 16'h1234);
    repeat (5) @(negedge clock);
    pulse(16'h5678, 16'h5678);
    warm(16'h5678);
    cyc(4'b1111, 4'b0001);
    cyc(4'b1111, 4'b0010);
    pulse(16'hBEEF, 16'hBEEF);
    warm(16'hBEEF);
    cyc(4'b1111, 4'b0001);
    cyc(4'b0000, 4'b0000);
    cyc(4'b0000, 4'b0000);
    check("scoreboard drained", exp_q.size(), 32'h0);
    check("lfsr never locked", {31'h0, lockup_seen}, 32'h0);
    resetn = 1'b0;
    #1;
    check("async reset rand_out", {16'h0, rand_out}, 32'h0);
    check("async reset gen_seed", {16'h0, gen_seed}, 32'h0);
    check("async reset ready", {31'h0, ready}, 32'h0);
    @(negedge clock);
    resetn = 1'b1;
`ifdef LFSR_SHARE_ARBITER_STATS_EN
    pulse(16'hACE1, 16'hACE1);
    warm(16'hACE1);
    for (int i = 0; i < 70000; i++) cyc(4'b0010, 4'b0010);
    cyc(4'b0000, 4'b0000);
    stat_sel = 3'd1;
    #1;
    check("stat saturated", {16'h0, stat_cnt}, 32'hFFFF);
    @(negedge clock);
    stat_clr = 1'b1;
    @(negedge clock);
    stat_clr = 1'b0;
    check("stat cleared", {16'h0, stat_cnt}, 32'h0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule

// File: doc/lfsr_share_arbiter.md
LFSR_SHARE_ARBITER -- requirements
Module: lfsr_share_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one 16-bit LFSR generator (range 2..8).
REQ-002 Parameter WARMUP, default 16, number of free-run cycles discarded after every seed load (range 1..255).
REQ-003 clock  input  1  clock; all state updates on its rising edge.
REQ-004 resetn  input  1  reset; asynchronous, active-low.
REQ-005 seed_load  input  1  single-cycle pulse; start a seed/warm-up sequence.
REQ-006 seed  input  16  seed value, sampled when seed_load=1.
REQ-007 req  input  NUM_REQ  per-requester request; held high until granted.
REQ-008 gnt  output  NUM_REQ  one-hot grant, registered, one-cycle pulse.
REQ-009 rand_out  output  16  random word delivered with gnt.
REQ-010 rand_valid  output  1  high in exactly the cycles gnt is non-zero.
REQ-011 ready  output  1  high only in RUN state.
REQ-012 gen_load  output  1  drives the generator load input.
REQ-013 gen_seed  output  16  drives the generator seed input.
REQ-014 gen_rand  input  16  generator output; advances one LFSR step every cycle gen_load=0.

Function
REQ-015 FSM states: IDLE, LOAD, WARM, RUN; encoding free.
REQ-016 IDLE: gnt=0, ready=0; seed_load=1 -> LOAD.
REQ-017 LOAD lasts exactly one cycle with gen_load=1, gen_seed=captured seed; then WARM with warm counter=WARMUP-1.
REQ-018 WARM: counter decrements per cycle; transition to RUN in the cycle after counter=0; no grants issued.
REQ-019 seed_load=1 in any state (incl. LOAD, WARM, RUN) -> LOAD next cycle; any grant already registered still completes; no new grant issued from that cycle.
REQ-020 Seed sanitising: captured seed 16'hFFFF (XNOR-LFSR lock-up state) replaced by 16'hFFFE; all other values passed unchanged.
REQ-021 RUN: round-robin arbitration over req; priority starts at index one above the last granted index (wrap NUM_REQ-1 -> 0); after reset/seed load the pointer starts at index 0.
REQ-022 Latency: req[i] sampled high at edge t and selected -> gnt[i]=1, rand_valid=1, rand_out=gen_rand sampled at t, all visible after edge t (one cycle).
REQ-023 At most one grant per cycle; back-to-back grants permitted, so consecutive grants carry consecutive LFSR states.
REQ-024 Requester must drop req in the cycle after its gnt; req still high then is treated as a new request.
REQ-025 req=0 in RUN -> gnt=0, rand_valid=0, rand_out holds last value, pointer unchanged.

Reset
REQ-026 resetn=0 asynchronously forces: state IDLE, gnt=0, rand_valid=0, rand_out=16'h0000, ready=0, gen_load=0, gen_seed=16'h0000, pointer=0, warm counter=0.
REQ-027 After resetn release, no grant is issued until a full LOAD+WARM sequence completes.

Configuration
REQ-028 Macro LFSR_SHARE_ARBITER_STATS_EN: when defined, per-requester 16-bit saturating grant counters plus inputs stat_sel (3 bits) and stat_clr (1 bit) and output stat_cnt (16 bits, combinational read of counter stat_sel) are compiled in; stat_clr=1 zeroes all counters, dominating a same-cycle increment; counters reset to 0 and survive seed loads.
REQ-029 Without the macro, stat ports, counters and their logic are absent; all other behaviour identical.

Structure
REQ-030 Shared package holds the FSM state typedef, LFSR_LOCKUP=16'hFFFF, LFSR_LOCKUP_FIX=16'hFFFE, and the WARMUP/NUM_REQ defaults.
REQ-031 One sub-module: rr_arbiter (parameterised NUM_REQ, combinational one-hot pick given req and pointer); FSM, registers and stats stay in lfsr_share_arbiter.
REQ-032 The generator is instantiated outside this block, wired via gen_load/gen_seed/gen_rand.

Verification
REQ-033 Reset then seed_load with seed=16'hACE1 -> gen_load high for exactly 1 cycle, gen_seed=16'hACE1, ready rises 1+WARMUP cycles after LOAD.
REQ-034 seed=16'hFFFF -> gen_seed=16'hFFFE; generator reference model never reaches 16'hFFFF.
REQ-035 RUN, req=4'b1111 held continuously (re-asserted after each grant) -> gnt sequence 0001,0010,0100,1000,0001; rand_out equals the reference LFSR states on consecutive cycles.
REQ-036 RUN, only req[2] high -> gnt=4'b0100 after one cycle; next grant with req=4'b1011 goes to index 3.
REQ-037 seed_load asserted mid-WARM and again mid-RUN with requests pending -> no grant until new warm-up completes; pointer back to 0.
REQ-038 With LFSR_SHARE_ARBITER_STATS_EN: 70000 grants to requester 1 -> stat_cnt saturates at 16'hFFFF; stat_clr -> 0.
